// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: drives loads/stores onto a req/ack data memory, formats store lanes,
// extends load data and registers the results into the MEM/WB boundary.
module mem_stage_unit #(
  parameter int INST_SZ = 32,
  parameter int ADDR_SZ = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_halt,
  input  logic               i_mem_write,
  input  logic [2:0]         i_bhw,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic               i_bds_sel,
  input  logic [INST_SZ-1:0] i_alu_result,
  input  logic [INST_SZ-1:0] i_write_data,
  input  logic [4:0]         i_write_register,
  input  logic [INST_SZ-1:0] i_bds,
  output logic               o_dm_req,
  output logic               o_dm_we,
  output logic [ADDR_SZ-1:0] o_dm_addr,
  output logic [3:0]         o_dm_be,
  output logic [INST_SZ-1:0] o_dm_wdata,
  input  logic               i_dm_ack,
  input  logic [INST_SZ-1:0] i_dm_rdata,
  output logic               o_stall,
  output logic               o_halt,
  output logic               o_reg_write,
  output logic               o_mem_to_reg,
  output logic               o_bds_sel,
  output logic [INST_SZ-1:0] o_read_data,
  output logic [INST_SZ-1:0] o_alu_result,
  output logic [4:0]         o_write_register,
  output logic [INST_SZ-1:0] o_bds,
  output logic               o_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [3:0] lane_be(input logic [1:0] bsel, input logic [1:0] off);
    case (bsel)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [INST_SZ-1:0] lane_data(input logic [1:0] bsel,
                                                   input logic [INST_SZ-1:0] wd);
    case (bsel)
      2'b00:   lane_data = {4{wd[7:0]}};
      2'b01:   lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  function automatic logic [INST_SZ-1:0] load_ext(input logic [1:0] bsel, input logic uns,
                                                  input logic [1:0] off,
                                                  input logic [INST_SZ-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = rd[16*off[1] +: 16];
    case (bsel)
      2'b00:   load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = rd;
    endcase
  endfunction

  state_t state_q, state_d;
  logic [INST_SZ-1:0] rdata_buf_q, rdata_buf_d;

  logic               halt_q, halt_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               bds_sel_q, bds_sel_d;
  logic [INST_SZ-1:0] read_data_q, read_data_d;
  logic [INST_SZ-1:0] alu_result_q, alu_result_d;
  logic [4:0]         write_register_q, write_register_d;
  logic [INST_SZ-1:0] bds_q, bds_d;
  logic               misaligned_q, misaligned_d;

  logic               is_load, mem_op, misaligned, access;
  logic               dm_req, latch, use_buf;
  logic [1:0]         off;
  logic [INST_SZ-1:0] rdata_src;

  assign off        = i_alu_result[1:0];
  assign is_load    = i_mem_to_reg & i_reg_write;
  assign mem_op     = i_mem_write | is_load;
  // Size code 10 is treated as a word access, so bhw[1] alone selects word alignment.
  assign misaligned = mem_op & (((i_bhw[1:0] == 2'b01) & off[0]) | (i_bhw[1] & (|off)));
  assign access     = mem_op & ~misaligned;

  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    dm_req      = 1'b0;
    latch       = 1'b0;
    use_buf     = 1'b0;
    case (state_q)
      S_IDLE: begin
        dm_req = i_enable & access;
        if (i_enable) begin
          if (!access || i_dm_ack) latch = 1'b1;
          else                     state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dm_req = 1'b1;
        if (i_dm_ack) begin
          if (i_enable) begin
            latch   = 1'b1;
            state_d = S_IDLE;
          end else begin
            rdata_buf_d = i_dm_rdata;
            state_d     = S_HOLD;
          end
        end
      end
      // Access already completed while the stage was frozen; no second request is issued.
      S_HOLD: begin
        use_buf = 1'b1;
        if (i_enable) begin
          latch   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_reset) dm_req = 1'b0;
  end

  assign rdata_src = use_buf ? rdata_buf_q : i_dm_rdata;

  always_comb begin
    halt_d           = halt_q;
    reg_write_d      = reg_write_q;
    mem_to_reg_d     = mem_to_reg_q;
    bds_sel_d        = bds_sel_q;
    read_data_d      = read_data_q;
    alu_result_d     = alu_result_q;
    write_register_d = write_register_q;
    bds_d            = bds_q;
    misaligned_d     = misaligned_q;
    if (latch) begin
      halt_d           = i_halt;
      reg_write_d      = i_reg_write & ~misaligned;
      mem_to_reg_d     = i_mem_to_reg;
      bds_sel_d        = i_bds_sel;
      read_data_d      = (is_load & ~misaligned) ? load_ext(i_bhw[1:0], i_bhw[2], off, rdata_src)
                                                 : '0;
      alu_result_d     = i_alu_result;
      write_register_d = i_write_register;
      bds_d            = i_bds;
      misaligned_d     = misaligned;
    end
  end

  // MEM/WB boundary
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= S_IDLE;
      halt_q           <= 1'b0;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      bds_sel_q        <= 1'b0;
      read_data_q      <= '0;
      alu_result_q     <= '0;
      write_register_q <= '0;
      bds_q            <= '0;
      misaligned_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      halt_q           <= halt_d;
      reg_write_q      <= reg_write_d;
      mem_to_reg_q     <= mem_to_reg_d;
      bds_sel_q        <= bds_sel_d;
      read_data_q      <= read_data_d;
      alu_result_q     <= alu_result_d;
      write_register_q <= write_register_d;
      bds_q            <= bds_d;
      misaligned_q     <= misaligned_d;
    end
  end

  always_ff @(posedge i_clk) begin
    rdata_buf_q <= rdata_buf_d;
  end

  assign o_dm_req         = dm_req;
  assign o_dm_we          = i_mem_write;
  assign o_dm_addr        = i_alu_result[ADDR_SZ+1:2];
  assign o_dm_be          = i_mem_write ? lane_be(i_bhw[1:0], off) : 4'b1111;
  assign o_dm_wdata       = lane_data(i_bhw[1:0], i_write_data);
  assign o_stall          = dm_req & ~i_dm_ack;

  assign o_halt           = halt_q;
  assign o_reg_write      = reg_write_q;
  assign o_mem_to_reg     = mem_to_reg_q;
  assign o_bds_sel        = bds_sel_q;
  assign o_read_data      = read_data_q;
  assign o_alu_result     = alu_result_q;
  assign o_write_register = write_register_q;
  assign o_bds            = bds_q;
  assign o_misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed cases plus random load/store/ALU traffic against a
// byte-addressed reference memory and a randomly delayed acknowledging data memory.
module tb_mem_stage_unit;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_halt, i_mem_write, i_reg_write, i_mem_to_reg, i_bds_sel;
  logic [2:0]  i_bhw;
  logic [31:0] i_alu_result, i_write_data, i_bds, i_dm_rdata;
  logic [4:0]  i_write_register;
  logic        i_dm_ack;
  logic        o_dm_req, o_dm_we, o_stall, o_halt, o_reg_write, o_mem_to_reg, o_bds_sel;
  logic [9:0]  o_dm_addr;
  logic [3:0]  o_dm_be;
  logic [31:0] o_dm_wdata, o_read_data, o_alu_result, o_bds;
  logic [4:0]  o_write_register;
  logic        o_misaligned;

  mem_stage_unit #(.INST_SZ(32), .ADDR_SZ(10)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_halt(i_halt),
    .i_mem_write(i_mem_write), .i_bhw(i_bhw), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .i_bds_sel(i_bds_sel), .i_alu_result(i_alu_result),
    .i_write_data(i_write_data), .i_write_register(i_write_register), .i_bds(i_bds),
    .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be),
    .o_dm_wdata(o_dm_wdata), .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
    .o_stall(o_stall), .o_halt(o_halt), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_bds_sel(o_bds_sel), .o_read_data(o_read_data),
    .o_alu_result(o_alu_result), .o_write_register(o_write_register), .o_bds(o_bds),
    .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_dut [0:31];
  logic [7:0]  bmem    [0:127];

  logic        e_halt, e_reg_write, e_mem_to_reg, e_bds_sel, e_mis;
  logic [31:0] e_rd, e_alu, e_bds;
  logic [4:0]  e_wr;

  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic [9:0]  last_addr;
  int          stall_cnt, req_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string ctx);
    chk({ctx, ".halt"},       32'(o_halt),           32'(e_halt));
    chk({ctx, ".reg_write"},  32'(o_reg_write),      32'(e_reg_write));
    chk({ctx, ".mem_to_reg"}, 32'(o_mem_to_reg),     32'(e_mem_to_reg));
    chk({ctx, ".bds_sel"},    32'(o_bds_sel),        32'(e_bds_sel));
    chk({ctx, ".read_data"},  o_read_data,           e_rd);
    chk({ctx, ".alu_result"}, o_alu_result,          e_alu);
    chk({ctx, ".write_reg"},  32'(o_write_register), 32'(e_wr));
    chk({ctx, ".bds"},        o_bds,                 e_bds);
    chk({ctx, ".misaligned"}, 32'(o_misaligned),     32'(e_mis));
  endtask

  task automatic clear_model();
    e_halt = 0; e_reg_write = 0; e_mem_to_reg = 0; e_bds_sel = 0; e_mis = 0;
    e_rd = 0; e_alu = 0; e_bds = 0; e_wr = 0;
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem_dut[w] = v;
    for (int i = 0; i < 4; i++) bmem[4*w+i] = v[8*i +: 8];
  endtask

  task automatic set_nop();
    i_enable = 1; i_halt = 0; i_mem_write = 0; i_bhw = 0; i_reg_write = 0;
    i_mem_to_reg = 0; i_bds_sel = 0; i_alu_result = 0; i_write_data = 0;
    i_write_register = 0; i_bds = 0; i_dm_ack = 0; i_dm_rdata = 0;
  endtask

  // Little-endian byte read of sz bytes at a, sign-extended numerically unless uns.
  function automatic logic [31:0] model_load(input int a, input int sz, input bit uns);
    longint v = 0;
    for (int i = 0; i < sz; i++) v += longint'(bmem[a+i]) << (8*i);
    if (!uns && sz < 4 && v >= (longint'(1) << (8*sz-1))) v -= longint'(1) << (8*sz);
    return v[31:0];
  endfunction

  // One instruction, entered and left just after a falling edge.
  task automatic run_op(input logic mw, input logic ld, input logic [2:0] bhw,
                        input logic [31:0] a, input logic [31:0] wd, input int lat,
                        input logic [31:0] bds, input logic [4:0] wr,
                        input logic halt, input logic bsel);
    int          sz, off, w, m;
    bit          memop, mis, exp_req;
    logic [3:0]  eb;
    logic [31:0] nrd;
    sz    = (bhw[1:0] == 2'b00) ? 1 : (bhw[1:0] == 2'b01) ? 2 : 4;
    off   = int'(a[1:0]);
    w     = int'(a[6:2]);
    memop = mw | ld;
    mis   = memop && ((int'(a) % sz) != 0);
    exp_req = memop && !mis;
    m     = ((1 << sz) - 1) << off;
    eb    = mw ? m[3:0] : 4'hf;
    i_enable = 1; i_halt = halt; i_mem_write = mw; i_bhw = bhw; i_reg_write = ~mw;
    i_mem_to_reg = ld; i_bds_sel = bsel; i_alu_result = a; i_write_data = wd;
    i_write_register = wr; i_bds = bds;
    nrd = (ld && !mis) ? model_load(int'(a[6:0]), sz, bhw[2]) : 32'd0;
    stall_cnt = 0; req_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      i_dm_ack   = exp_req && (c >= lat);
      i_dm_rdata = exp_req ? mem_dut[w] : $urandom;
      #1;
      if (o_stall) stall_cnt++;
      if (o_dm_req) req_cnt++;
      chk("req", 32'(o_dm_req), 32'(exp_req));
      chk("stall", 32'(o_stall), 32'(exp_req && c < lat));
      if (c > 0) check_outs("hold");
      if (exp_req) begin
        last_be = o_dm_be; last_wdata = o_dm_wdata; last_addr = o_dm_addr;
        chk("we", 32'(o_dm_we), 32'(mw));
        chk("addr", 32'(o_dm_addr), {22'd0, a[11:2]});
        chk("be", 32'(o_dm_be), 32'(eb));
        if (mw) for (int i = 0; i < sz; i++)
          chk("wdata_lane", 32'(o_dm_wdata[8*(off+i) +: 8]), 32'(wd[8*i +: 8]));
        if (i_dm_ack && mw)
          for (int b = 0; b < 4; b++)
            if (o_dm_be[b]) mem_dut[w][8*b +: 8] = o_dm_wdata[8*b +: 8];
      end
      @(posedge i_clk);
      if (!exp_req || c >= lat) break;
      @(negedge i_clk);
    end
    @(negedge i_clk);
    i_dm_ack = 0;
    if (mw && !mis) for (int i = 0; i < sz; i++) bmem[int'(a[6:0]) + i] = wd[8*i +: 8];
    e_halt = halt; e_reg_write = ~mw & ~mis; e_mem_to_reg = ld; e_bds_sel = bsel;
    e_rd = nrd; e_alu = a; e_wr = wr; e_bds = bds; e_mis = mis;
    check_outs("op");
  endtask

  // Word load whose ack arrives while the stage is frozen; result appears after re-enable.
  task automatic run_hold_load(input logic [31:0] a);
    int w;
    w = int'(a[6:2]);
    i_enable = 1; i_halt = 0; i_mem_write = 0; i_bhw = 3'b011; i_reg_write = 1;
    i_mem_to_reg = 1; i_bds_sel = 0; i_alu_result = a; i_write_data = $urandom;
    i_write_register = 5'd9; i_bds = 32'h1234_0008; i_dm_ack = 0; i_dm_rdata = $urandom;
    #1;
    chk("hold_req0", 32'(o_dm_req), 32'd1);
    chk("hold_stall0", 32'(o_stall), 32'd1);
    @(posedge i_clk); @(negedge i_clk);
    i_enable = 0; i_dm_ack = 1; i_dm_rdata = mem_dut[w];
    #1;
    chk("hold_req1", 32'(o_dm_req), 32'd1);
    chk("hold_stall1", 32'(o_stall), 32'd0);
    check_outs("hold_ack");
    @(posedge i_clk); @(negedge i_clk);
    i_dm_ack = 0; i_dm_rdata = ~mem_dut[w];
    #1;
    chk("hold_req2", 32'(o_dm_req), 32'd0);
    check_outs("hold_frozen");
    @(posedge i_clk); @(negedge i_clk);
    i_enable = 1;
    #1;
    chk("hold_req3", 32'(o_dm_req), 32'd0);
    chk("hold_stall3", 32'(o_stall), 32'd0);
    @(posedge i_clk); @(negedge i_clk);
    e_halt = 0; e_reg_write = 1; e_mem_to_reg = 1; e_bds_sel = 0; e_mis = 0;
    e_rd = model_load(int'(a[6:0]), 4, 0); e_alu = a; e_wr = 5'd9; e_bds = 32'h1234_0008;
    check_outs("hold_done");
    #1;
    chk("hold_req4", 32'(o_dm_req), 32'd1);
    set_nop();
  endtask

  initial begin
    logic [31:0] r;
    set_nop();
    i_reset = 1;
    for (int w = 0; w < 32; w++) set_word(w, $urandom);
    clear_model();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 0;
    #1;
    chk("reset_req", 32'(o_dm_req), 32'd0);
    check_outs("reset");

    // lb / lbu of the top byte lane
    set_word(4, 32'h80FF_7F00);
    run_op(0, 1, 3'b000, 32'h13, 32'd0, 0, 32'h8, 5'd3, 0, 0);
    chk("lb_be", 32'(last_be), 32'hF);
    chk("lb_data", o_read_data, 32'hFFFF_FF80);
    run_op(0, 1, 3'b100, 32'h13, 32'd0, 1, 32'h8, 5'd3, 0, 0);
    chk("lbu_data", o_read_data, 32'h0000_0080);

    // sh to the upper half of word 8
    run_op(1, 0, 3'b001, 32'h22, 32'h0000_ABCD, 1, 32'h10, 5'd0, 0, 1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_addr", 32'(last_addr), 32'd8);
    chk("sh_reg_write", 32'(o_reg_write), 32'd0);

    // lw with three wait states
    run_op(0, 1, 3'b011, 32'h40, 32'd0, 3, 32'h20, 5'd7, 0, 0);
    chk("lw_stall_cycles", stall_cnt, 32'd3);

    // misaligned lw
    run_op(0, 1, 3'b011, 32'h41, 32'd0, 2, 32'h24, 5'd8, 0, 0);
    chk("mis_flag", 32'(o_misaligned), 32'd1);
    chk("mis_reg_write", 32'(o_reg_write), 32'd0);
    chk("mis_no_req", req_cnt, 32'd0);

    // back-to-back ALU ops
    for (int k = 0; k < 4; k++) begin
      r = $urandom;
      run_op(0, 0, 3'($urandom), r, $urandom, 0, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      chk("add_stall", stall_cnt, 32'd0);
    end

    run_hold_load(32'h0000_001C);

    // reset while a load is waiting for its ack
    run_op(0, 0, 3'b011, 32'hDEAD_BEEF, 32'd0, 0, 32'h44, 5'd31, 1, 1);
    i_bhw = 3'b011; i_mem_to_reg = 1; i_reg_write = 1; i_alu_result = 32'h8;
    i_halt = 0; i_dm_ack = 0;
    #1;
    chk("rst_wait_req", 32'(o_dm_req), 32'd1);
    @(posedge i_clk); @(negedge i_clk);
    i_reset = 1; set_nop();
    #1;
    chk("rst_during_req", 32'(o_dm_req), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 0;
    #1;
    clear_model();
    chk("rst_mid_req", 32'(o_dm_req), 32'd0);
    check_outs("rst_mid");

    // random traffic over bytes 0..63
    for (int k = 0; k < 250; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
             $urandom, $urandom_range(0, 3), $urandom, 5'($urandom), 1'($urandom),
             1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
